// File: rtl/mem_stage_sp_if.sv
// Handshake and bundle signals between the EX/MEM register, the memory stage and MEM/WB.
// master = upstream/consumer side, slave = the memory stage itself.
interface mem_stage_sp_if #(
  parameter int W  = 16,
  parameter int AW = 11
);
  // in_valid/in_ready: a bundle transfers on a rising clk edge where both are high;
  // in_valid must hold fields stable until that edge. out_valid is a one-cycle pulse
  // with no back-pressure; the output fields hold their value until the next pulse.
  logic          in_valid;
  logic          in_ready;
  logic          mem_read;
  logic          mem_write;
  logic          addr_sel;
  logic          data_sel;
  logic [1:0]    sp_op;
  logic [2:0]    wb_in;
  logic [W-1:0]  rsrc;
  logic [W-1:0]  rdst;
  logic [W-1:0]  alu;
  logic [W-1:0]  imm;
  logic          out_valid;
  logic [2:0]    wb_out;
  logic [W-1:0]  imm_out;
  logic [W-1:0]  alu_out;
  logic [W-1:0]  mem_out;
  logic [AW-1:0] sp_out;
  logic          sp_fault;
  logic [1:0]    state_dbg;

  modport master (
    output in_valid, mem_read, mem_write, addr_sel, data_sel, sp_op, wb_in,
           rsrc, rdst, alu, imm,
    input  in_ready, out_valid, wb_out, imm_out, alu_out, mem_out, sp_out,
           sp_fault, state_dbg
  );

  modport slave (
    input  in_valid, mem_read, mem_write, addr_sel, data_sel, sp_op, wb_in,
           rsrc, rdst, alu, imm,
    output in_ready, out_valid, wb_out, imm_out, alu_out, mem_out, sp_out,
           sp_fault, state_dbg
  );
endinterface

// File: rtl/mem_stage_sp.sv
// Pipeline memory-access stage with internal data memory, stack pointer (PUSH/POP)
// and a configurable wait-state count; emits a registered write-back bundle.
module mem_stage_sp #(
  parameter int W       = 16,
  parameter int AW      = 11,
  parameter int LAT     = 1,
  parameter int SP_INIT = 2**AW - 1
) (
  input  logic         clk,
  input  logic         rst,
  mem_stage_sp_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;

  localparam bit            HAS_WAIT = (LAT > 0);
  localparam logic [2:0]    LAT_M1   = (LAT > 0) ? 3'(LAT - 1) : 3'd0;
  localparam logic [AW-1:0] SP_RST   = AW'(SP_INIT);

  state_t state, state_n;
  logic [2:0] cnt;

  logic         h_mem_read, h_mem_write, h_addr_sel, h_data_sel;
  logic [1:0]   h_sp_op;
  logic [2:0]   h_wb;
  logic [W-1:0] h_rsrc, h_rdst, h_alu, h_imm;

  logic [W-1:0]  mem [0:2**AW-1];
  logic [AW-1:0] sp_q, sp_pend;
  logic          sp_fault_q;
  logic          wr_en_q;
  logic [AW-1:0] wr_addr_q;
  logic [W-1:0]  wr_data_q;
  logic [2:0]    wb_q;
  logic [W-1:0]  imm_q, alu_q, mem_q;

  // In IDLE the bundle is still on the bus (LAT = 0 reaches DONE on the accept
  // edge); afterwards the held copy is used.
  logic         s_mem_read, s_mem_write, s_addr_sel, s_data_sel;
  logic [1:0]   s_sp_op;
  logic [2:0]   s_wb;
  logic [W-1:0] s_rsrc, s_rdst, s_alu, s_imm;

  logic          accept, enter_done;
  logic          s_push, s_pop, s_mem_op, push_fault, pop_fault;
  logic          rd_en, wr_en;
  logic [W-1:0]  s_addr_full, s_wdata;
  logic [AW-1:0] s_addr, rd_addr, wr_addr, sp_n;

  always_comb begin
    if (state == IDLE) begin
      s_mem_read  = bus.mem_read;
      s_mem_write = bus.mem_write;
      s_addr_sel  = bus.addr_sel;
      s_data_sel  = bus.data_sel;
      s_sp_op     = bus.sp_op;
      s_wb        = bus.wb_in;
      s_rsrc      = bus.rsrc;
      s_rdst      = bus.rdst;
      s_alu       = bus.alu;
      s_imm       = bus.imm;
    end else begin
      s_mem_read  = h_mem_read;
      s_mem_write = h_mem_write;
      s_addr_sel  = h_addr_sel;
      s_data_sel  = h_data_sel;
      s_sp_op     = h_sp_op;
      s_wb        = h_wb;
      s_rsrc      = h_rsrc;
      s_rdst      = h_rdst;
      s_alu       = h_alu;
      s_imm       = h_imm;
    end
  end

  assign accept     = bus.in_valid && (state == IDLE);
  assign s_push     = (s_sp_op == 2'b01);
  assign s_pop      = (s_sp_op == 2'b10);
  assign s_mem_op   = s_mem_read | s_mem_write | s_push | s_pop;
  assign push_fault = s_push && (sp_q == '0);
  assign pop_fault  = s_pop && (sp_q == '1);

  assign s_addr_full = s_addr_sel ? s_rdst : s_rsrc;
  assign s_addr      = s_addr_full[AW-1:0];
  assign s_wdata     = s_data_sel ? s_rdst : s_rsrc;

  // Stack ops override mem_read/mem_write; a read+write pair is a plain write.
  always_comb begin
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    rd_addr = s_addr;
    wr_addr = s_addr;
    sp_n    = sp_q;
    if (s_push) begin
      wr_en   = !push_fault;
      wr_addr = sp_q;
      if (!push_fault) sp_n = sp_q - 1'b1;
    end else if (s_pop) begin
      rd_en   = !pop_fault;
      rd_addr = sp_q + 1'b1;
      if (!pop_fault) sp_n = sp_q + 1'b1;
    end else begin
      wr_en = s_mem_write;
      rd_en = s_mem_read && !s_mem_write;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (accept) state_n = (s_mem_op && HAS_WAIT) ? WAIT : DONE;
      WAIT: if (cnt == 3'd0) state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign enter_done = (state_n == DONE) && (state != DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 3'd0;
      h_mem_read  <= 1'b0;
      h_mem_write <= 1'b0;
      h_addr_sel  <= 1'b0;
      h_data_sel  <= 1'b0;
      h_sp_op     <= 2'b00;
      h_wb        <= 3'b000;
      h_rsrc      <= '0;
      h_rdst      <= '0;
      h_alu       <= '0;
      h_imm       <= '0;
      wb_q        <= 3'b000;
      imm_q       <= '0;
      alu_q       <= '0;
      mem_q       <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      sp_q        <= SP_RST;
      sp_pend     <= SP_RST;
      sp_fault_q  <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        h_mem_read  <= bus.mem_read;
        h_mem_write <= bus.mem_write;
        h_addr_sel  <= bus.addr_sel;
        h_data_sel  <= bus.data_sel;
        h_sp_op     <= bus.sp_op;
        h_wb        <= bus.wb_in;
        h_rsrc      <= bus.rsrc;
        h_rdst      <= bus.rdst;
        h_alu       <= bus.alu;
        h_imm       <= bus.imm;
        cnt         <= LAT_M1;
      end else if (state == WAIT && cnt != 3'd0) begin
        cnt <= cnt - 3'd1;
      end
      if (enter_done) begin
        wb_q      <= s_wb;
        imm_q     <= s_imm;
        alu_q     <= s_alu;
        mem_q     <= rd_en ? mem[rd_addr] : '0;
        wr_en_q   <= wr_en;
        wr_addr_q <= wr_addr;
        wr_data_q <= s_wdata;
        sp_pend   <= sp_n;
        if (push_fault || pop_fault) sp_fault_q <= 1'b1;
      end
      // Write and SP update commit on the edge that leaves DONE.
      if (state == DONE) begin
        sp_q    <= sp_pend;
        wr_en_q <= 1'b0;
      end
    end
  end

  // Gated by DONE, so a reset during WAIT drops the pending write.
  always_ff @(posedge clk) begin
    if (state == DONE && wr_en_q) mem[wr_addr_q] <= wr_data_q;
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.wb_out    = wb_q;
  assign bus.imm_out   = imm_q;
  assign bus.alu_out   = alu_q;
  assign bus.mem_out   = mem_q;
  assign bus.sp_out    = sp_q;
  assign bus.sp_fault  = sp_fault_q;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_mem_stage_sp.sv
// Bench for mem_stage_sp: LAT = 2 instance (a) and LAT = 0 instance (b), directed bundles
// with hand-computed results checked by a negedge monitor against per-instance queues.
module tb_mem_stage_sp;

  typedef struct {
    logic [2:0]  wb;
    logic [15:0] imm;
    logic [15:0] alu;
    logic [15:0] mem;
    int          lat;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t qa[$];
  exp_t qb[$];

  mem_stage_sp_if #(.W(16), .AW(11)) busa ();
  mem_stage_sp_if #(.W(16), .AW(11)) busb ();

  mem_stage_sp #(.W(16), .AW(11), .LAT(2), .SP_INIT(2047)) dut_a (
    .clk(clk), .rst(rst), .bus(busa)
  );
  mem_stage_sp #(.W(16), .AW(11), .LAT(0), .SP_INIT(2047)) dut_b (
    .clk(clk), .rst(rst), .bus(busb)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (busa.out_valid) begin
      if (qa.size() == 0) chk("a_unexpected_out_valid", 32'd1, 32'd0);
      else begin
        e = qa.pop_front();
        chk("a_wb_out", 32'(busa.wb_out), 32'(e.wb));
        chk("a_imm_out", 32'(busa.imm_out), 32'(e.imm));
        chk("a_alu_out", 32'(busa.alu_out), 32'(e.alu));
        chk("a_mem_out", 32'(busa.mem_out), 32'(e.mem));
        chk("a_latency", 32'(cyc - e.acc + 1), 32'(e.lat));
      end
    end
    if (busb.out_valid) begin
      if (qb.size() == 0) chk("b_unexpected_out_valid", 32'd1, 32'd0);
      else begin
        e = qb.pop_front();
        chk("b_wb_out", 32'(busb.wb_out), 32'(e.wb));
        chk("b_imm_out", 32'(busb.imm_out), 32'(e.imm));
        chk("b_alu_out", 32'(busb.alu_out), 32'(e.alu));
        chk("b_mem_out", 32'(busb.mem_out), 32'(e.mem));
        chk("b_latency", 32'(cyc - e.acc + 1), 32'(e.lat));
      end
    end
  end

  // driver tasks
  task automatic drive(input int d, input logic v, input logic mr, input logic mw,
                       input logic as, input logic ds, input logic [1:0] op,
                       input logic [2:0] wb, input logic [15:0] rs, input logic [15:0] rd,
                       input logic [15:0] al, input logic [15:0] im);
    if (d == 0) begin
      busa.in_valid = v;  busa.mem_read = mr; busa.mem_write = mw; busa.addr_sel = as;
      busa.data_sel = ds; busa.sp_op = op;    busa.wb_in = wb;     busa.rsrc = rs;
      busa.rdst = rd;     busa.alu = al;      busa.imm = im;
    end else begin
      busb.in_valid = v;  busb.mem_read = mr; busb.mem_write = mw; busb.addr_sel = as;
      busb.data_sel = ds; busb.sp_op = op;    busb.wb_in = wb;     busb.rsrc = rs;
      busb.rdst = rd;     busb.alu = al;      busb.imm = im;
    end
  endtask

  // Presents one bundle until accepted; queues the expected result unless no_exp.
  task automatic send(input int d, input logic mr, input logic mw, input logic as,
                      input logic ds, input logic [1:0] op, input logic [2:0] wb,
                      input logic [15:0] rs, input logic [15:0] rd, input logic [15:0] al,
                      input logic [15:0] im, input logic [15:0] emem, input int elat,
                      input bit no_exp, output int acc);
    logic rdy;
    bit   ok;
    exp_t e;
    ok  = 1'b0;
    acc = -1;
    drive(d, 1'b1, mr, mw, as, ds, op, wb, rs, rd, al, im);
    for (int i = 0; i < 50; i++) begin
      rdy = (d == 0) ? busa.in_ready : busb.in_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    else begin
      acc = cyc;
      if (!no_exp) begin
        e = '{wb: wb, imm: im, alu: al, mem: emem, lat: elat, acc: cyc};
        if (d == 0) qa.push_back(e);
        else qb.push_back(e);
      end
    end
    drive(d, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 16'h0, 16'h0, 16'h0, 16'h0);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (qa.size() == 0 && qb.size() == 0 && busa.in_ready && busb.in_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int a0, a1, a2;
    drive(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 16'h0, 16'h0, 16'h0, 16'h0);
    drive(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 16'h0, 16'h0, 16'h0, 16'h0);

    // reset state
    @(negedge clk);
    chk("rst_out_valid", 32'(busa.out_valid), 32'd0);
    chk("rst_in_ready", 32'(busa.in_ready), 32'd1);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_wb_out", 32'(busa.wb_out), 32'd0);
    chk("rst_imm_out", 32'(busa.imm_out), 32'd0);
    chk("rst_alu_out", 32'(busa.alu_out), 32'd0);
    chk("rst_mem_out", 32'(busa.mem_out), 32'd0);
    chk("rst_sp_out", 32'(busa.sp_out), 32'h7FF);
    chk("rst_sp_fault", 32'(busa.sp_fault), 32'd0);

    // non-memory op, latency 1
    send(0, 0, 0, 0, 0, 2'b00, 3'b101, 16'h0, 16'h0, 16'h00AA, 16'h0F0F, 16'h0, 1, 0, a0);
    // write 0x1234 to 0x0005 via rdst address, then read it back
    send(0, 0, 1, 1, 0, 2'b00, 3'b010, 16'h1234, 16'h0005, 16'h0011, 16'h0022, 16'h0, 3, 0, a0);
    send(0, 1, 0, 0, 0, 2'b00, 3'b011, 16'h0005, 16'h0000, 16'h0033, 16'h0044, 16'h1234, 3, 0, a1);
    chk("a_accept_gap", 32'(a1 - a0), 32'd4);
    // reserved sp_op behaves as no-op
    send(0, 0, 0, 0, 0, 2'b11, 3'b110, 16'h0, 16'h0, 16'h5555, 16'hAAAA, 16'h0, 1, 0, a0);
    // read+write conflict is a write, mem_out 0
    send(0, 1, 1, 1, 0, 2'b00, 3'b001, 16'h5A5A, 16'h0020, 16'h0, 16'h0, 16'h0, 3, 0, a0);
    send(0, 1, 0, 1, 0, 2'b00, 3'b001, 16'h0000, 16'h0020, 16'h0, 16'h0, 16'h5A5A, 3, 0, a0);

    // reset during WAIT aborts the write of 0xBEEF
    send(0, 0, 1, 0, 1, 2'b00, 3'b000, 16'h0010, 16'h1111, 16'h0, 16'h0, 16'h0, 3, 0, a0);
    wait_idle();
    send(0, 0, 1, 0, 1, 2'b00, 3'b000, 16'h0010, 16'hBEEF, 16'h0, 16'h0, 16'h0, 3, 1, a0);
    chk("a_state_wait", 32'(busa.state_dbg), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_out_valid_0", 32'(busa.out_valid), 32'd0);
    @(negedge clk);
    chk("abort_out_valid_1", 32'(busa.out_valid), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    chk("abort_sp_out", 32'(busa.sp_out), 32'h7FF);
    send(0, 1, 0, 0, 0, 2'b00, 3'b000, 16'h0010, 16'h0, 16'h0, 16'h0, 16'h1111, 3, 0, a0);
    wait_idle();

    // pop straight after reset underflows
    send(0, 0, 0, 0, 0, 2'b10, 3'b100, 16'h0, 16'h0, 16'h0001, 16'h0002, 16'h0, 3, 0, a0);
    wait_idle();
    chk("uf_sp_fault", 32'(busa.sp_fault), 32'd1);
    chk("uf_sp_out", 32'(busa.sp_out), 32'h7FF);

    // push then pop
    send(0, 0, 0, 1, 0, 2'b01, 3'b001, 16'hCAFE, 16'h0123, 16'h0, 16'h0, 16'h0, 3, 0, a0);
    wait_idle();
    chk("push_sp_out", 32'(busa.sp_out), 32'h7FE);
    send(0, 0, 0, 0, 0, 2'b10, 3'b001, 16'h0, 16'h0, 16'h0, 16'h0, 16'hCAFE, 3, 0, a0);
    wait_idle();
    chk("pop_sp_out", 32'(busa.sp_out), 32'h7FF);
    chk("pop_sp_fault_sticky", 32'(busa.sp_fault), 32'd1);
    // push with data from rdst, mem_read/mem_write ignored
    send(0, 1, 1, 0, 1, 2'b01, 3'b111, 16'h1111, 16'h0BAD, 16'h0, 16'h0, 16'h0, 3, 0, a0);
    send(0, 0, 0, 0, 0, 2'b10, 3'b111, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0BAD, 3, 0, a0);
    wait_idle();
    chk("push2_sp_out", 32'(busa.sp_out), 32'h7FF);

    // LAT = 0 instance: back-to-back reads, latency 1, accepted every 2 cycles
    send(1, 0, 1, 0, 1, 2'b00, 3'b010, 16'h0003, 16'h7777, 16'h0, 16'h0, 16'h0, 1, 0, a0);
    send(1, 1, 0, 0, 0, 2'b00, 3'b011, 16'h0003, 16'h0, 16'h0, 16'h0, 16'h7777, 1, 0, a1);
    send(1, 1, 0, 1, 0, 2'b00, 3'b100, 16'h0, 16'h0003, 16'h0, 16'h0, 16'h7777, 1, 0, a2);
    chk("b_accept_gap_1", 32'(a1 - a0), 32'd2);
    chk("b_accept_gap_2", 32'(a2 - a1), 32'd2);
    wait_idle();

    chk("qa_drained", 32'(qa.size()), 32'd0);
    chk("qb_drained", 32'(qb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
